// File: rtl/addsub_serial.sv
// Multi-cycle adder/subtractor: B is conditionally inverted and the sum is
// formed CHUNK bits per cycle through a registered carry, with valid/ready on both sides.
module addsub_serial #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [31:0]      base;
  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic             msb_cin;
  logic             last_beat;
  logic             accept;

  assign base      = 32'(cnt_q) * 32'(CHUNK);
  assign a_chunk   = a_q[base +: CHUNK];
  assign b_chunk   = b_q[base +: CHUNK];
  assign chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
  // Carry into the MSB recovered from the sum bit: s = a ^ b ^ cin.
  assign msb_cin   = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];
  assign last_beat = (cnt_q == CW'(N - 1));
  assign accept    = (state_q == IDLE) && in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (last_beat) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they carry no input path.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      a_q     <= data_a;
      b_q     <= data_b ^ {WIDTH{sub}};
      carry_q <= sub;
      cnt_q   <= '0;
    end else if (state_q == BUSY) begin
      result[base +: CHUNK] <= chunk_sum[CHUNK-1:0];
      carry_q               <= chunk_sum[CHUNK];
      if (last_beat) begin
        carry_out <= chunk_sum[CHUNK];
        overflow  <= msb_cin ^ chunk_sum[CHUNK];
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial: directed cases plus randomized operations over several
// WIDTH/CHUNK configurations, checked against a plain-arithmetic reference.
module tb_addsub_serial;

  localparam int NCFG = 4;
  localparam int unsigned W_TAB [NCFG] = '{32, 32, 16, 64};
  localparam int unsigned C_TAB [NCFG] = '{8, 32, 4, 8};

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] data_a = '0;
  logic [63:0] data_b = '0;
  logic        sub = 1'b0;
  logic        in_valid    [NCFG];
  logic        out_ready   [NCFG];
  logic        in_ready_w  [NCFG];
  logic        out_valid_w [NCFG];
  logic        carry_w     [NCFG];
  logic        ovf_w       [NCFG];
  logic [63:0] result_w    [NCFG];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int unsigned W = W_TAB[g];
    localparam int unsigned C = C_TAB[g];
    logic [W-1:0] res;

    addsub_serial #(.WIDTH(W), .CHUNK(C)) u_dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready_w[g]),
      .data_a    (data_a[W-1:0]),
      .data_b    (data_b[W-1:0]),
      .sub       (sub),
      .out_valid (out_valid_w[g]),
      .out_ready (out_ready[g]),
      .result    (res),
      .carry_out (carry_w[g]),
      .overflow  (ovf_w[g])
    );

    assign result_w[g] = 64'(res);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] wmask(input int unsigned w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  // Reference: unsigned sum/difference for result and carry, sign rules for overflow.
  task automatic model(input int unsigned w, input logic [63:0] a, input logic [63:0] b,
                       input logic s, output logic [63:0] r, output logic c, output logic o);
    logic [63:0] m, am, bm;
    logic [64:0] sum;
    logic        sa, sb, sr;
    m  = wmask(w);
    am = a & m;
    bm = b & m;
    if (!s) begin
      sum = {1'b0, am} + {1'b0, bm};
      r   = sum[63:0] & m;
      c   = sum[w];
    end else begin
      r = (am - bm) & m;
      c = (am >= bm);
    end
    sa = am[w-1];
    sb = bm[w-1];
    sr = r[w-1];
    o  = s ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
  endtask

  function automatic logic [63:0] rand_op(input int unsigned w);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    case ($urandom_range(0, 7))
      0: r = '0;
      1: r = '1;
      2: r = 64'd1 << (w - 1);
      3: r = (64'd1 << (w - 1)) - 64'd1;
      default: ;
    endcase
    return r & wmask(w);
  endfunction

  task automatic do_op(input int g, input logic [63:0] a, input logic [63:0] b,
                       input logic s, input int hold, input string tag);
    logic [63:0] er;
    logic        ec, eo;
    int          n, waited, lat;
    model(W_TAB[g], a, b, s, er, ec, eo);
    n = int'(W_TAB[g] / C_TAB[g]);
    waited = 0;
    @(negedge clock);
    while (!in_ready_w[g] && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    if (!in_ready_w[g]) begin
      check({tag, " ready_wait"}, 64'(in_ready_w[g]), 64'd1);
      return;
    end
    data_a = a;
    data_b = b;
    sub = s;
    in_valid[g] = 1'b1;
    out_ready[g] = 1'b0;
    @(posedge clock);
    #1;
    in_valid[g] = 1'b0;
    data_a = {$urandom(), $urandom()};
    data_b = {$urandom(), $urandom()};
    sub = 1'($urandom());
    check({tag, " busy_in_ready"}, 64'(in_ready_w[g]), 64'd0);
    lat = 0;
    do begin
      @(posedge clock);
      #1;
      lat++;
    end while (!out_valid_w[g] && lat < n + 8);
    check({tag, " latency"}, 64'(lat), 64'(n));
    if (!out_valid_w[g]) return;
    check({tag, " result"}, result_w[g], er);
    check({tag, " carry"}, 64'(carry_w[g]), 64'(ec));
    check({tag, " overflow"}, 64'(ovf_w[g]), 64'(eo));
    for (int h = 0; h < hold; h++) begin
      in_valid[g] = 1'($urandom());
      data_a = {$urandom(), $urandom()};
      sub = 1'($urandom());
      @(posedge clock);
      #1;
      check({tag, " hold_valid"}, 64'(out_valid_w[g]), 64'd1);
      check({tag, " hold_in_ready"}, 64'(in_ready_w[g]), 64'd0);
      check({tag, " hold_result"}, result_w[g], er);
    end
    in_valid[g] = 1'b0;
    out_ready[g] = 1'b1;
    @(posedge clock);
    #1;
    out_ready[g] = 1'b0;
    check({tag, " post_valid"}, 64'(out_valid_w[g]), 64'd0);
    check({tag, " post_in_ready"}, 64'(in_ready_w[g]), 64'd1);
  endtask

  initial begin
    for (int i = 0; i < NCFG; i++) begin
      in_valid[i] = 1'b0;
      out_ready[i] = 1'b0;
    end
    #3;
    for (int i = 0; i < NCFG; i++) begin
      check("rst in_ready", 64'(in_ready_w[i]), 64'd0);
      check("rst out_valid", 64'(out_valid_w[i]), 64'd0);
      check("rst result", result_w[i], 64'd0);
      check("rst carry", 64'(carry_w[i]), 64'd0);
      check("rst overflow", 64'(ovf_w[i]), 64'd0);
    end
    @(negedge clock);
    reset_n = 1'b1;
    check("pre_edge in_ready", 64'(in_ready_w[0]), 64'd0);
    @(posedge clock);
    #1;
    check("first_edge in_ready", 64'(in_ready_w[0]), 64'd1);

    do_op(0, 64'h0000_00FF, 64'h0000_0001, 1'b0, 0, "ff_plus_1");
    do_op(0, 64'd3, 64'd5, 1'b1, 0, "3_minus_5");
    do_op(0, 64'd5, 64'd3, 1'b1, 0, "5_minus_3");
    do_op(0, 64'h7FFF_FFFF, 64'd1, 1'b0, 0, "pos_ovf");
    do_op(0, 64'h8000_0000, 64'd1, 1'b1, 0, "neg_ovf");
    do_op(0, 64'hFFFF_FFFF, 64'd1, 1'b0, 0, "wrap");
    do_op(0, 64'h1234_5678, 64'h0FED_CBA9, 1'b1, 5, "backpressure");

    // Abort an operation while its third beat is in progress.
    @(negedge clock);
    data_a = 64'hDEAD_BEEF;
    data_b = 64'h0BAD_F00D;
    sub = 1'b0;
    in_valid[0] = 1'b1;
    @(posedge clock);
    #1;
    in_valid[0] = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort in_ready", 64'(in_ready_w[0]), 64'd0);
    check("abort out_valid", 64'(out_valid_w[0]), 64'd0);
    check("abort result", result_w[0], 64'd0);
    check("abort carry", 64'(carry_w[0]), 64'd0);
    check("abort overflow", 64'(ovf_w[0]), 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("rerun in_ready", 64'(in_ready_w[0]), 64'd1);
    check("rerun out_valid", 64'(out_valid_w[0]), 64'd0);
    do_op(0, 64'd10, 64'd20, 1'b0, 0, "after_reset");

    for (int g = 0; g < NCFG; g++) begin
      int ops;
      ops = (g == 0) ? 200 : 1000;
      for (int k = 0; k < ops; k++) begin
        do_op(g, rand_op(W_TAB[g]), rand_op(W_TAB[g]), 1'($urandom()),
              int'($urandom_range(0, 3)), $sformatf("rand_cfg%0d", g));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
